mem_port_client: RTL and testbench
==================================

Name: mem_port_client

Overview:
- Requester-side endpoint of the shared-memory round-robin arbitration protocol.
- One instance sits on each arbitrated memory port, between a local compute engine and the shared memory bus.
- Accepts burst read/write commands and raises req to the arbiter. Once granted it owns the bus, issues consecutive word accesses, holds req until all read data has returned, then releases for at least one cycle.

Parameters:
- ADDR_W, 16, memory word-address width.
- DATA_W, 32, memory data width.
- LEN_W, 8, burst length field width (words).
- RD_LAT, 1, memory read latency in cycles; must be >= 1.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- cmd_valid  input  1  command offered
- cmd_ready  output  1  block can accept a command
- cmd_wr  input  1  1=write burst, 0=read burst
- cmd_addr  input  ADDR_W  first word address
- cmd_len  input  LEN_W  number of words
- wr_data  input  DATA_W  local write word
- wr_valid  input  1  wr_data available
- wr_pop  output  1  wr_data consumed this cycle
- rd_data  output  DATA_W  returned read word (mem_rdata passthrough)
- rd_valid  output  1  rd_data valid this cycle
- done  output  1  one-cycle pulse when a command completes
- err  output  1  sticky protocol-violation flag
- req  output  1  arbitration request, this port's bit
- grant  input  1  arbitration grant, this port's bit
- mem_addr  output  ADDR_W  bus address
- mem_we  output  1  write strobe
- mem_re  output  1  read strobe
- mem_wdata  output  DATA_W  bus write data
- mem_rdata  input  DATA_W  bus read data, RD_LAT cycles after mem_re

Behaviour:
- States: IDLE, REQ, XFER, DRAIN, REL. Reset (async) forces IDLE and clears the in-flight read pipe. Outputs at reset: req=0, cmd_ready=1 (IDLE), done=0, err=0, mem_we=mem_re=0, rd_valid=0, wr_pop=0, and the address counter=0.
- cmd_ready=1 only in IDLE. A command is accepted on the edge where cmd_valid&cmd_ready; cmd_wr, cmd_addr and cmd_len are latched.
- cmd_len=0: go straight to REL with no req and no bus access; done pulses in REL.
- REQ: req=1. Move to XFER on the edge where grant=1 is sampled. If grant is already parked on this port, XFER starts one cycle after REQ.
- XFER: req=1. A beat issues in any cycle where grant=1 and, for writes, wr_valid=1.
  - On a beat, mem_re or mem_we=1 and mem_addr=current address, driven combinationally.
  - For writes on a beat, mem_wdata=wr_data and wr_pop=1.
  - The write-data stall (wr_valid=0) holds req and issues no strobe.
- Address increments by 1 per beat and wraps modulo 2^ADDR_W. The remaining-count register decrements per beat.
- After the last beat: writes go to REL; reads go to DRAIN while any read is still outstanding.
- Read return: an RD_LAT-deep shift register tracks mem_re. rd_valid=tap[RD_LAT-1]; rd_data=mem_rdata. No backpressure on the read side.
- DRAIN: req=1, no strobes. Move to REL on the edge after the cycle carrying the final rd_valid, so req stays high through the last read return.
- REL: req=0, done=1 for this single cycle, cmd_ready=0. Next state is IDLE. This guarantees req is low for at least one cycle, so the arbiter rotates.
- Protocol violation: grant=0 while in XFER or DRAIN sets err=1 (sticky until rst).
  - No beat issues while grant=0.
  - The FSM continues once grant returns.
  - Reads already in flight still complete.
- Reset mid-operation: req, strobes and rd_valid drop immediately; in-flight data is discarded; no done pulse.
- Strobes are never asserted outside XFER. mem_we and mem_re are never high together.

Test Plan:
1. Read, len=4, addr=0x0010, RD_LAT=1, grant held high. Accept at edge 0 -> req=1 from cycle 1; mem_re cycles 2-5 at addr 0x10-0x13; rd_valid cycles 3-6; req=0 and done=1 at cycle 7; cmd_ready=1 at cycle 8.
2. Write, len=3, grant=0 until cycle 6. req is held high through cycles 1-5 with no strobes. mem_we in cycles 7-9 with data D0..D2, and wr_pop coincides with each.
3. Write, len=4, wr_valid=0 in the third beat cycle -> mem_we gap of 1 cycle, 4 strobes total, req held high throughout, done once.
4. Read, len=2, addr=0xFFFF, ADDR_W=16 -> mem_addr 0xFFFF then 0x0000; RD_LAT=3 -> req stays high until the cycle after the second rd_valid.
5. cmd_len=0 -> req never rises, done pulses 1 cycle after accept. Separately, drop grant mid-read -> err=1 and stays 1, and beats pause.
6. Assert rst during XFER of an 8-word read -> req, mem_re and rd_valid are 0 immediately, state returns to IDLE, cmd_ready=1 after release, and no done pulse occurs.

Source files
------------

// File: rtl/mem_port_client.sv
// mem_port_client: requester-side endpoint of the shared-memory round-robin
// arbitration protocol. It takes a burst command from the local engine,
// requests the bus, issues one word access per granted cycle, waits for all
// read returns, then drops req for one cycle so the arbiter can rotate.
//
// Handshakes: cmd_valid/cmd_ready is a strict valid/ready pair and a command
// transfers on the clock edge where both are high. wr_valid/wr_pop works the
// same way: a write word is consumed in a cycle where wr_pop is high, and
// wr_pop is only raised while wr_valid is high. Read returns have no
// backpressure, and rd_valid marks each returned word for exactly one cycle.
module mem_port_client #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  output logic              req,
  input  logic              grant,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_XFER  = 3'd2,
    S_DRAIN = 3'd3,
    S_REL   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [RD_LAT-1:0]  tap_q, tap_d;
  logic               req_q, ready_q, done_q, err_q;
  logic               accept;
  logic               beat;

  assign accept = cmd_valid & ready_q;
  // A beat needs the bus and, for writes, a word from the local engine.
  assign beat   = (state_q == S_XFER) & grant & (~wr_q | wr_valid);

  assign mem_re    = beat & ~wr_q;
  assign mem_we    = beat & wr_q;
  assign wr_pop    = mem_we;
  assign mem_wdata = mem_we ? wr_data : '0;
  assign mem_addr  = addr_q;

  assign rd_valid  = tap_q[RD_LAT-1];
  assign rd_data   = mem_rdata;

  assign req       = req_q;
  assign cmd_ready = ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

  // Read-return tracker: shift in each read strobe, one tap per cycle of latency.
  always_comb begin
    tap_d    = tap_q << 1;
    tap_d[0] = mem_re;
  end

  // Next-state selection for the burst FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (cmd_len == '0) ? S_REL : S_REQ;
      S_REQ:   if (grant) state_d = S_XFER;
      S_XFER:  if (beat && (cnt_q == LEN_W'(1))) state_d = wr_q ? S_REL : S_DRAIN;
      // No new reads issue here, so an empty next tap vector means the
      // current cycle carries the final return.
      S_DRAIN: if (tap_d == '0) state_d = S_REL;
      S_REL:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, command registers, read tracker and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      tap_q   <= '0;
      req_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      req_q   <= (state_d == S_REQ) || (state_d == S_XFER) || (state_d == S_DRAIN);
      ready_q <= (state_d == S_IDLE);
      done_q  <= (state_d == S_REL);
      if (accept) begin
        wr_q   <= cmd_wr;
        addr_q <= cmd_addr;
        cnt_q  <= cmd_len;
      end else if (beat) begin
        addr_q <= addr_q + ADDR_W'(1);
        cnt_q  <= cnt_q - LEN_W'(1);
      end
      // Losing the grant while owning the bus is a protocol violation.
      if (((state_q == S_XFER) || (state_q == S_DRAIN)) && !grant) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_client.sv
// Bench for mem_port_client: cycle tables for the directed scenarios, a reset
// sequence mid-burst, and random bursts scored against a transaction model.
module tb_mem_port_client;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          cmd_valid_a, cmd_valid_b, cmd_wr, wr_valid, grant;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] wr_data;

  logic          a_ready, a_pop, a_rv, a_done, a_err, a_req, a_we, a_re;
  logic [DW-1:0] a_rdata, a_wdata, a_mrdata;
  logic [AW-1:0] a_addr;
  logic [2:0]    a_state;
  logic          b_ready, b_pop, b_rv, b_done, b_err, b_req, b_we, b_re;
  logic [DW-1:0] b_rdata, b_wdata, b_mrdata;
  logic [AW-1:0] b_addr;
  logic [2:0]    b_state;

  mem_port_client #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RD_LAT(1)) u_a (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_a), .cmd_ready(a_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_pop(a_pop), .rd_data(a_rdata), .rd_valid(a_rv), .done(a_done), .err(a_err),
    .req(a_req), .grant(grant), .mem_addr(a_addr), .mem_we(a_we), .mem_re(a_re),
    .mem_wdata(a_wdata), .mem_rdata(a_mrdata), .dbg_state(a_state));

  mem_port_client #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RD_LAT(3)) u_b (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_b), .cmd_ready(b_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_pop(b_pop), .rd_data(b_rdata), .rd_valid(b_rv), .done(b_done), .err(b_err),
    .req(b_req), .grant(grant), .mem_addr(b_addr), .mem_we(b_we), .mem_re(b_re),
    .mem_wdata(b_wdata), .mem_rdata(b_mrdata), .dbg_state(b_state));

  // Memory content is a fixed function of the address.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {~a, a};
  endfunction

  // Memory models with 1- and 3-cycle read latency.
  logic [DW-1:0] a_pipe;
  logic [DW-1:0] b_pipe [3];
  always @(posedge clk) begin
    a_pipe    <= mem_word(a_addr);
    b_pipe[0] <= mem_word(b_addr);
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign a_mrdata = a_pipe;
  assign b_mrdata = b_pipe[2];

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [DW-1:0]    exp_q[$];
  logic [AW+DW:0]   beat_q[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    cmd_valid_a = 1'b0; cmd_valid_b = 1'b0; cmd_wr = 1'b0;
    cmd_addr = '0; cmd_len = '0; wr_data = '0; wr_valid = 1'b0; grant = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Table row: inputs {cmd_valid, grant, wr_valid}, expected {req, re, we, rv, done, rdy, err}.
  typedef struct {
    logic [2:0]    in;
    logic [DW-1:0] wd;
    logic [6:0]    ex;
    logic [AW-1:0] maddr;
    logic [DW-1:0] rdata;
  } vec_t;
  vec_t vecs[$];
  logic tbl_sel;

  function automatic vec_t mk(input logic [2:0] in, input logic [DW-1:0] wd,
                              input logic [6:0] ex, input logic [AW-1:0] ma,
                              input logic [DW-1:0] rd);
    vec_t v;
    v.in = in; v.wd = wd; v.ex = ex; v.maddr = ma; v.rdata = rd;
    return v;
  endfunction

  task automatic run_table(input string tag);
    logic s_req, s_re, s_we, s_rv, s_done, s_rdy, s_err, s_pop;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
    foreach (vecs[i]) begin
      cmd_valid_a = vecs[i].in[2] & ~tbl_sel;
      cmd_valid_b = vecs[i].in[2] & tbl_sel;
      grant = vecs[i].in[1];
      wr_valid = vecs[i].in[0];
      wr_data = vecs[i].wd;
      @(negedge clk);
      if (tbl_sel) begin
        s_req = b_req; s_re = b_re; s_we = b_we; s_rv = b_rv; s_done = b_done;
        s_rdy = b_ready; s_err = b_err; s_pop = b_pop; s_addr = b_addr;
        s_wdata = b_wdata; s_rdata = b_rdata;
      end else begin
        s_req = a_req; s_re = a_re; s_we = a_we; s_rv = a_rv; s_done = a_done;
        s_rdy = a_ready; s_err = a_err; s_pop = a_pop; s_addr = a_addr;
        s_wdata = a_wdata; s_rdata = a_rdata;
      end
      check($sformatf("%s c%0d req", tag, i), s_req, vecs[i].ex[6]);
      check($sformatf("%s c%0d mem_re", tag, i), s_re, vecs[i].ex[5]);
      check($sformatf("%s c%0d mem_we", tag, i), s_we, vecs[i].ex[4]);
      check($sformatf("%s c%0d wr_pop", tag, i), s_pop, vecs[i].ex[4]);
      check($sformatf("%s c%0d rd_valid", tag, i), s_rv, vecs[i].ex[3]);
      check($sformatf("%s c%0d done", tag, i), s_done, vecs[i].ex[2]);
      check($sformatf("%s c%0d cmd_ready", tag, i), s_rdy, vecs[i].ex[1]);
      check($sformatf("%s c%0d err", tag, i), s_err, vecs[i].ex[0]);
      if (vecs[i].ex[5] | vecs[i].ex[4])
        check($sformatf("%s c%0d mem_addr", tag, i), s_addr, vecs[i].maddr);
      if (vecs[i].ex[4])
        check($sformatf("%s c%0d mem_wdata", tag, i), s_wdata, vecs[i].wd);
      if (vecs[i].ex[3])
        check($sformatf("%s c%0d rd_data", tag, i), s_rdata, vecs[i].rdata);
      @(posedge clk); #1;
    end
    cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
  endtask

  // Random bursts on the RD_LAT=1 port, scored by a transaction model.
  task automatic run_random(input int n_cmds);
    logic          wr, saw_req, saw_done;
    logic [AW-1:0] base, a;
    logic [DW-1:0] d, r;
    logic [AW+DW:0] b;
    logic [DW-1:0] wbuf[$];
    int len, gdly, k, widx;
    for (int t = 0; t < n_cmds; t++) begin
      wr   = 1'($urandom_range(0, 1));
      base = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
      len  = $urandom_range(0, 6);
      gdly = $urandom_range(0, 4);
      wbuf.delete(); beat_q.delete(); exp_q.delete();
      for (int i = 0; i < len; i++) begin
        a = base + 16'(i);
        d = $urandom;
        if (wr) begin
          wbuf.push_back(d);
          beat_q.push_back({1'b1, a, d});
        end else begin
          beat_q.push_back({1'b0, a, 32'h0});
          exp_q.push_back(mem_word(a));
        end
      end
      cmd_wr = wr; cmd_addr = base; cmd_len = LW'(len);
      saw_req = 1'b0; saw_done = 1'b0; k = 0; widx = 0;
      while (!saw_done && k < 200) begin
        cmd_valid_a = (k == 0);
        grant = (k == 0) ? 1'($urandom_range(0, 1)) : (k > gdly);
        wr_valid = ($urandom_range(0, 3) != 0);
        wr_data = (widx < wbuf.size()) ? wbuf[widx] : $urandom;
        @(negedge clk);
        if (k == 0) check($sformatf("rnd%0d cmd_ready", t), a_ready, 1'b1);
        check($sformatf("rnd%0d we&re", t), a_we & a_re, 1'b0);
        check($sformatf("rnd%0d wr_pop", t), a_pop, a_we);
        if (a_we | a_re) begin
          check($sformatf("rnd%0d strobe grant", t), grant & a_req, 1'b1);
          if (a_we) check($sformatf("rnd%0d we wr_valid", t), wr_valid, 1'b1);
          if (beat_q.size() == 0) begin
            check($sformatf("rnd%0d extra beat", t), 1'b1, 1'b0);
          end else begin
            b = beat_q.pop_front();
            check($sformatf("rnd%0d beat kind", t), a_we, b[AW+DW]);
            check($sformatf("rnd%0d beat addr", t), a_addr, b[AW+DW-1:DW]);
            if (a_we) check($sformatf("rnd%0d beat wdata", t), a_wdata, b[DW-1:0]);
          end
        end
        if (a_pop) widx++;
        if (a_rv) begin
          if (exp_q.size() == 0) begin
            check($sformatf("rnd%0d extra rd_valid", t), 1'b1, 1'b0);
          end else begin
            r = exp_q.pop_front();
            check($sformatf("rnd%0d rd_data", t), a_rdata, r);
          end
        end
        if (a_req) saw_req = 1'b1;
        if (a_done) begin
          saw_done = 1'b1;
          check($sformatf("rnd%0d req at done", t), a_req, 1'b0);
        end
        @(posedge clk); #1;
        k++;
      end
      cmd_valid_a = 1'b0;
      check($sformatf("rnd%0d done seen", t), saw_done, 1'b1);
      check($sformatf("rnd%0d beats left", t), 32'(beat_q.size()), 32'd0);
      check($sformatf("rnd%0d reads left", t), 32'(exp_q.size()), 32'd0);
      check($sformatf("rnd%0d err", t), a_err, 1'b0);
      if (len == 0) check($sformatf("rnd%0d req on empty", t), saw_req, 1'b0);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic saw_done;

    do_reset();
    @(negedge clk);
    check("reset req", a_req, 1'b0);
    check("reset cmd_ready", a_ready, 1'b1);
    check("reset done", a_done, 1'b0);
    check("reset err", a_err, 1'b0);
    check("reset strobes", {a_we, a_re, a_rv, a_pop}, 4'b0);
    check("reset addr", a_addr, 16'h0);
    check("reset state", a_state, 3'd0);
    @(posedge clk); #1;

    // Read len 4 @0x10, grant held.
    do_reset();
    tbl_sel = 1'b0; cmd_wr = 1'b0; cmd_addr = 16'h0010; cmd_len = 8'd4;
    vecs.delete();
    vecs.push_back(mk(3'b110, 32'h0, 7'b0000010, 16'h0000, 32'h0));
    vecs.push_back(mk(3'b010, 32'h0, 7'b1000000, 16'h0000, 32'h0));
    vecs.push_back(mk(3'b010, 32'h0, 7'b1100000, 16'h0010, 32'h0));
    vecs.push_back(mk(3'b010, 32'h0, 7'b1101000, 16'h0011, mem_word(16'h0010)));
    vecs.push_back(mk(3'b010, 32'h0, 7'b1101000, 16'h0012, mem_word(16'h0011)));
    vecs.push_back(mk(3'b010, 32'h0, 7'b1101000, 16'h0013, mem_word(16'h0012)));
    vecs.push_back(mk(3'b010, 32'h0, 7'b1001000, 16'h0000, mem_word(16'h0013)));
    vecs.push_back(mk(3'b010, 32'h0, 7'b0000100, 16'h0000, 32'h0));
    vecs.push_back(mk(3'b010, 32'h0, 7'b0000010, 16'h0000, 32'h0));
    run_table("rd4");

    // Write len 3 @0x40, grant withheld until cycle 6.
    do_reset();
    tbl_sel = 1'b0; cmd_wr = 1'b1; cmd_addr = 16'h0040; cmd_len = 8'd3;
    vecs.delete();
    vecs.push_back(mk(3'b101, 32'hEEEE_EEEE, 7'b0000010, 16'h0, 32'h0));
    for (int c = 1; c <= 5; c++)
      vecs.push_back(mk(3'b001, 32'hEEEE_EEEE, 7'b1000000, 16'h0, 32'h0));
    vecs.push_back(mk(3'b011, 32'hEEEE_EEEE, 7'b1000000, 16'h0, 32'h0));
    vecs.push_back(mk(3'b011, 32'hD000_0000, 7'b1010000, 16'h0040, 32'h0));
    vecs.push_back(mk(3'b011, 32'hD000_0001, 7'b1010000, 16'h0041, 32'h0));
    vecs.push_back(mk(3'b011, 32'hD000_0002, 7'b1010000, 16'h0042, 32'h0));
    vecs.push_back(mk(3'b011, 32'hEEEE_EEEE, 7'b0000100, 16'h0, 32'h0));
    vecs.push_back(mk(3'b011, 32'hEEEE_EEEE, 7'b0000010, 16'h0, 32'h0));
    run_table("wr3gnt");

    // Write len 4 @0x100, wr_valid low in the third beat cycle.
    do_reset();
    tbl_sel = 1'b0; cmd_wr = 1'b1; cmd_addr = 16'h0100; cmd_len = 8'd4;
    vecs.delete();
    vecs.push_back(mk(3'b111, 32'hEEEE_EEEE, 7'b0000010, 16'h0, 32'h0));
    vecs.push_back(mk(3'b011, 32'hEEEE_EEEE, 7'b1000000, 16'h0, 32'h0));
    vecs.push_back(mk(3'b011, 32'hC000_0000, 7'b1010000, 16'h0100, 32'h0));
    vecs.push_back(mk(3'b011, 32'hC000_0001, 7'b1010000, 16'h0101, 32'h0));
    vecs.push_back(mk(3'b010, 32'hEEEE_EEEE, 7'b1000000, 16'h0, 32'h0));
    vecs.push_back(mk(3'b011, 32'hC000_0002, 7'b1010000, 16'h0102, 32'h0));
    vecs.push_back(mk(3'b011, 32'hC000_0003, 7'b1010000, 16'h0103, 32'h0));
    vecs.push_back(mk(3'b011, 32'hEEEE_EEEE, 7'b0000100, 16'h0, 32'h0));
    vecs.push_back(mk(3'b011, 32'hEEEE_EEEE, 7'b0000010, 16'h0, 32'h0));
    run_table("wr4stall");

    // Read len 2 @0xFFFF on the RD_LAT=3 port: address wraps, req covers both returns.
    do_reset();
    tbl_sel = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'hFFFF; cmd_len = 8'd2;
    vecs.delete();
    vecs.push_back(mk(3'b110, 32'h0, 7'b0000010, 16'h0, 32'h0));
    vecs.push_back(mk(3'b010, 32'h0, 7'b1000000, 16'h0, 32'h0));
    vecs.push_back(mk(3'b010, 32'h0, 7'b1100000, 16'hFFFF, 32'h0));
    vecs.push_back(mk(3'b010, 32'h0, 7'b1100000, 16'h0000, 32'h0));
    vecs.push_back(mk(3'b010, 32'h0, 7'b1000000, 16'h0, 32'h0));
    vecs.push_back(mk(3'b010, 32'h0, 7'b1001000, 16'h0, mem_word(16'hFFFF)));
    vecs.push_back(mk(3'b010, 32'h0, 7'b1001000, 16'h0, mem_word(16'h0000)));
    vecs.push_back(mk(3'b010, 32'h0, 7'b0000100, 16'h0, 32'h0));
    vecs.push_back(mk(3'b010, 32'h0, 7'b0000010, 16'h0, 32'h0));
    run_table("rdwrap");

    // Zero-length command: no req, done one cycle after accept.
    do_reset();
    tbl_sel = 1'b0; cmd_wr = 1'b0; cmd_addr = 16'h1234; cmd_len = 8'd0;
    vecs.delete();
    vecs.push_back(mk(3'b110, 32'h0, 7'b0000010, 16'h0, 32'h0));
    vecs.push_back(mk(3'b010, 32'h0, 7'b0000100, 16'h0, 32'h0));
    vecs.push_back(mk(3'b010, 32'h0, 7'b0000010, 16'h0, 32'h0));
    run_table("len0");

    // Grant dropped mid-read: beat pauses, err rises and sticks.
    do_reset();
    tbl_sel = 1'b0; cmd_wr = 1'b0; cmd_addr = 16'h0200; cmd_len = 8'd4;
    vecs.delete();
    vecs.push_back(mk(3'b110, 32'h0, 7'b0000010, 16'h0, 32'h0));
    vecs.push_back(mk(3'b010, 32'h0, 7'b1000000, 16'h0, 32'h0));
    vecs.push_back(mk(3'b010, 32'h0, 7'b1100000, 16'h0200, 32'h0));
    vecs.push_back(mk(3'b000, 32'h0, 7'b1001000, 16'h0, mem_word(16'h0200)));
    vecs.push_back(mk(3'b010, 32'h0, 7'b1100001, 16'h0201, 32'h0));
    vecs.push_back(mk(3'b010, 32'h0, 7'b1101001, 16'h0202, mem_word(16'h0201)));
    vecs.push_back(mk(3'b010, 32'h0, 7'b1101001, 16'h0203, mem_word(16'h0202)));
    vecs.push_back(mk(3'b010, 32'h0, 7'b1001001, 16'h0, mem_word(16'h0203)));
    vecs.push_back(mk(3'b010, 32'h0, 7'b0000101, 16'h0, 32'h0));
    vecs.push_back(mk(3'b010, 32'h0, 7'b0000011, 16'h0, 32'h0));
    run_table("gntdrop");

    // Reset asserted during an 8-word read.
    do_reset();
    cmd_wr = 1'b0; cmd_addr = 16'h0300; cmd_len = 8'd8; grant = 1'b1;
    cmd_valid_a = 1'b1;
    @(posedge clk); #1;
    cmd_valid_a = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("rstmid pre mem_re", a_re, 1'b1);
    check("rstmid pre rd_valid", a_rv, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("rstmid req", a_req, 1'b0);
    check("rstmid mem_re", a_re, 1'b0);
    check("rstmid rd_valid", a_rv, 1'b0);
    check("rstmid state", a_state, 3'd0);
    @(posedge clk); #1 rst = 1'b0;
    saw_done = 1'b0;
    @(negedge clk);
    check("rstmid cmd_ready", a_ready, 1'b1);
    for (int c = 0; c < 10; c++) begin
      if (a_done | a_req | a_re) saw_done = 1'b1;
      @(negedge clk);
    end
    check("rstmid no activity", saw_done, 1'b0);
    @(posedge clk); #1;

    // Random bursts.
    do_reset();
    run_random(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "timeout");
  end

endmodule
